// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Generic pipeline stage register for the RV32IM 5-stage core
//             (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a packed payload with a
//             valid bit and ready/valid backpressure. Supports synchronous
//             flush (bubble insertion) and an optional 2-entry skid buffer
//             that registers in_ready. Saturating stall/flush event counters
//             feed the performance monitor.
//  Ports    : clk, rst (async, active-high)
//             flush                      - kill all held entries
//             in_valid/in_ready/in_data  - upstream handshake + payload
//             out_valid/out_ready/out_data - downstream handshake + payload
//             stall_cnt                  - cycles with out_valid & ~out_ready
//             flush_cnt                  - cycles with flush asserted
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int unsigned       DATA_W = 128,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
    parameter int unsigned       SKID   = 1,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL1 = 2'd1,
        S_FULL2 = 2'd2
    } state_t;

    generate
        if (SKID == 0) begin : g_single
            // ----------------------------------------------------------------
            // Single register: ready passes straight through from downstream.
            // ----------------------------------------------------------------
            logic              r_valid;
            logic [DATA_W-1:0] r_data;
            logic              w_acc;
            logic              w_xfer;

            assign in_ready = out_ready | ~r_valid;
            assign w_acc    = in_valid & in_ready;
            assign w_xfer   = r_valid & out_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= BUBBLE;
                end else if (flush) begin
                    r_valid <= 1'b0;
                    r_data  <= BUBBLE;
                end else if (w_acc) begin
                    r_valid <= 1'b1;
                    r_data  <= in_data;
                end else if (w_xfer) begin
                    r_valid <= 1'b0;
                    r_data  <= BUBBLE;
                end
            end

            assign out_valid = r_valid;
            assign out_data  = r_data;
        end else begin : g_skid
            // ----------------------------------------------------------------
            // Main + skid register. in_ready is a flop so the upstream ready
            // path never sees out_ready combinationally; the skid entry absorbs
            // the one beat that may arrive after downstream stalls.
            // ----------------------------------------------------------------
            state_t            r_state;
            state_t            w_state_nxt;
            logic [DATA_W-1:0] r_main;
            logic [DATA_W-1:0] w_main_nxt;
            logic [DATA_W-1:0] r_skid;
            logic [DATA_W-1:0] w_skid_nxt;
            logic              r_in_ready;
            logic              w_acc;
            logic              w_xfer;

            assign w_acc  = in_valid & r_in_ready;
            assign w_xfer = (r_state != S_EMPTY) & out_ready;

            always_comb begin
                w_state_nxt = r_state;
                w_main_nxt  = r_main;
                w_skid_nxt  = r_skid;
                if (flush) begin
                    w_state_nxt = S_EMPTY;
                    w_main_nxt  = BUBBLE;
                    w_skid_nxt  = BUBBLE;
                end else begin
                    case (r_state)
                        S_EMPTY: begin
                            if (w_acc) begin
                                w_main_nxt  = in_data;
                                w_state_nxt = S_FULL1;
                            end
                        end
                        S_FULL1: begin
                            if (w_acc && w_xfer) begin
                                w_main_nxt = in_data;
                            end else if (w_acc) begin
                                w_skid_nxt  = in_data;
                                w_state_nxt = S_FULL2;
                            end else if (w_xfer) begin
                                w_main_nxt  = BUBBLE;
                                w_state_nxt = S_EMPTY;
                            end
                        end
                        S_FULL2: begin
                            // in_ready is low here, so only a drain can happen
                            if (w_xfer) begin
                                w_main_nxt  = r_skid;
                                w_skid_nxt  = BUBBLE;
                                w_state_nxt = S_FULL1;
                            end
                        end
                        default: begin
                            w_state_nxt = S_EMPTY;
                            w_main_nxt  = BUBBLE;
                            w_skid_nxt  = BUBBLE;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state    <= S_EMPTY;
                    r_main     <= BUBBLE;
                    r_skid     <= BUBBLE;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_main     <= w_main_nxt;
                    r_skid     <= w_skid_nxt;
                    r_in_ready <= (w_state_nxt != S_FULL2);
                end
            end

            assign in_ready  = r_in_ready;
            assign out_valid = (r_state != S_EMPTY);
            assign out_data  = r_main;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Saturating event counters. A flush cycle that is also stalled counts in
    // both, since out_valid reflects the state before the flush edge.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_evt;

    assign w_stall_evt = out_valid & ~out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (flush && (r_flush_cnt != c_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
